gen_layer_sequencer: RTL and testbench
======================================

GEN_LAYER_SEQUENCER -- requirements
Module: gen_layer_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 40000: max cycles waited for any single layer done.
REQ-002 Parameter CNT_W, default 16: width of cycle and frame counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request one generator pass; sampled in IDLE only.
REQ-006 abort  in  1  synchronous abort of the pass in progress.
REQ-007 l1_start, l2_start, l3_start  out  1 each  one-cycle start pulses to generator layers 1..3.
REQ-008 l1_done, l2_done, l3_done  in  1 each  layer completion strobes.
REQ-009 out_latch  out  1  one-cycle pulse to capture the layer-3 output bus.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse at pass completion.
REQ-012 error  out  1  sticky timeout flag, cleared by next accepted start or rst.
REQ-013 err_layer  out  2  layer index (1..3) that timed out; 0 if none.
REQ-014 pass_cycles  out  CNT_W  cycles of the last completed pass, saturating.
REQ-015 frame_cnt  out  CNT_W  completed passes, wraps modulo 2^CNT_W.

Function
REQ-016 FSM states: IDLE, L1_GO, L1_WAIT, L2_GO, L2_WAIT, L3_GO, L3_WAIT, FIN, ERR.
REQ-017 IDLE -> L1_GO when start=1; start in any other state is ignored.
REQ-018 Ln_GO asserts ln_start for exactly one cycle, then -> Ln_WAIT unconditionally.
REQ-019 ln_done is sampled only in Ln_WAIT; done strobes of other layers or in Ln_GO are ignored.
REQ-020 L1_WAIT -> L2_GO and L2_WAIT -> L3_GO on own done; L3_WAIT -> FIN on l3_done.
REQ-021 FIN: out_latch=1 and done=1 for one cycle, frame_cnt increments, pass_cycles updated, -> IDLE.
REQ-022 Latency: l1_start is high the cycle after start is sampled; done is high the cycle after l3_done is sampled.
REQ-023 Cycle counter clears on accepted start, increments each busy cycle, saturates at 2^CNT_W-1.
REQ-024 abort=1 in any busy state -> IDLE next cycle; no done, no out_latch, frame_cnt unchanged; abort has priority over done strobes in the same cycle.
REQ-025 Outputs registered; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 forces IDLE immediately; all start pulses, out_latch, busy, done, error = 0; err_layer, pass_cycles, frame_cnt = 0.
REQ-027 rst asserted mid-pass discards the pass with no done pulse.

Configuration
REQ-028 With GEN_SEQ_TIMEOUT_EN defined: per-layer wait counter clears on entering Ln_WAIT; reaching TIMEOUT_CYCLES without ln_done -> ERR, error=1, err_layer=n; ERR -> IDLE next cycle, busy=0.
REQ-029 Without GEN_SEQ_TIMEOUT_EN: no wait counter, ERR unreachable, error and err_layer tied to 0, waits are unbounded.

Structure
REQ-030 Shared package gen_pkg holds the FSM state enumeration, layer index constants (1..3), and default TIMEOUT_CYCLES.
REQ-031 One sub-module, gen_wait_timer (loadable up-counter with terminal flag), is instantiated only under GEN_SEQ_TIMEOUT_EN.

Verification
REQ-032 Nominal: start pulse; layer models assert done after 10, 20, 30 cycles -> l1/l2/l3_start each pulse once in order, single done and out_latch, frame_cnt=1, pass_cycles equals measured busy count.
REQ-033 Ordering: assert l2_done and l3_done during L1_WAIT -> ignored; FSM stays in L1_WAIT until l1_done.
REQ-034 Abort: abort in L2_WAIT together with l2_done -> IDLE next cycle, no l3_start, no done, frame_cnt unchanged.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=50): l2_done never asserted -> error=1, err_layer=2 after 50 wait cycles; next start clears error.
REQ-036 Reset: rst in L3_WAIT -> busy=0 and all outputs 0 asynchronously; subsequent start runs a full clean pass.
REQ-037 Back-to-back: start held high across FIN -> second pass begins the cycle after returning to IDLE; frame_cnt=2 after both complete.

Source files
------------

// File: rtl/gen_pkg.sv
// Shared types and constants for the generator layer sequencer.
package gen_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1_GO,
    ST_L1_WAIT,
    ST_L2_GO,
    ST_L2_WAIT,
    ST_L3_GO,
    ST_L3_WAIT,
    ST_FIN,
    ST_ERR
  } gen_state_e;

  localparam logic [1:0] LAYER_NONE = 2'd0;
  localparam logic [1:0] LAYER_1    = 2'd1;
  localparam logic [1:0] LAYER_2    = 2'd2;
  localparam logic [1:0] LAYER_3    = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 40000;

  function automatic logic is_go(gen_state_e s);
    return (s == ST_L1_GO) || (s == ST_L2_GO) || (s == ST_L3_GO);
  endfunction

  function automatic logic is_wait(gen_state_e s);
    return (s == ST_L1_WAIT) || (s == ST_L2_WAIT) || (s == ST_L3_WAIT);
  endfunction

  function automatic logic [1:0] wait_layer(gen_state_e s);
    case (s)
      ST_L1_WAIT: return LAYER_1;
      ST_L2_WAIT: return LAYER_2;
      ST_L3_WAIT: return LAYER_3;
      default:    return LAYER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gen_wait_timer.sv
// Loadable up-counter with a terminal flag; raised on the LIMIT-th enabled cycle after load.
module gen_wait_timer #(
  parameter int unsigned LIMIT = 40000,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic term
);

  logic [W-1:0] count_q, count_d;

  assign term = (count_q == W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !term) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gen_layer_sequencer.sv
// Sequences three generator layers (start/done handshakes) and latches the final output.
// Per-layer wait timeout is built only when GEN_SEQ_TIMEOUT_EN is defined.
module gen_layer_sequencer
  import gen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             l1_start,
  output logic             l2_start,
  output logic             l3_start,
  input  logic             l1_done,
  input  logic             l2_done,
  input  logic             l3_done,
  output logic             out_latch,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_layer,
  output logic [CNT_W-1:0] pass_cycles,
  output logic [CNT_W-1:0] frame_cnt
);

  gen_state_e       state_q, state_d;
  logic             l1_start_q, l1_start_d;
  logic             l2_start_q, l2_start_d;
  logic             l3_start_q, l3_start_d;
  logic             out_latch_q, out_latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [1:0]       err_layer_q, err_layer_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] pass_cycles_q, pass_cycles_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

`ifdef GEN_SEQ_TIMEOUT_EN
  logic tmr_load, tmr_en, tmr_term;

  assign tmr_load = is_go(state_q);
  assign tmr_en   = is_wait(state_q);
  assign tmo_hit  = tmr_term;

  gen_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .term (tmr_term)
  );
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d       = state_q;
    out_latch_d   = 1'b0;
    done_d        = 1'b0;
    error_d       = error_q;
    err_layer_d   = err_layer_q;
    cyc_d         = cyc_q;
    pass_cycles_d = pass_cycles_q;
    frame_cnt_d   = frame_cnt_q;

    if (state_q != ST_IDLE) begin
      cyc_d = sat_inc(cyc_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_L1_GO;
          cyc_d       = '0;
          error_d     = 1'b0;
          err_layer_d = LAYER_NONE;
        end
      end
      ST_L1_GO: state_d = ST_L1_WAIT;
      ST_L1_WAIT: begin
        if (l1_done)      state_d = ST_L2_GO;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_L2_GO: state_d = ST_L2_WAIT;
      ST_L2_WAIT: begin
        if (l2_done)      state_d = ST_L3_GO;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_L3_GO: state_d = ST_L3_WAIT;
      ST_L3_WAIT: begin
        if (l3_done) begin
          state_d       = ST_FIN;
          out_latch_d   = 1'b1;
          done_d        = 1'b1;
          frame_cnt_d   = frame_cnt_q + 1'b1;
          // Count includes the current L3_WAIT cycle and the FIN cycle that follows.
          pass_cycles_d = sat_inc(sat_inc(cyc_q));
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
      error_d     = 1'b1;
      err_layer_d = wait_layer(state_q);
    end

    // Abort wins over any done strobe seen in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      out_latch_d   = 1'b0;
      done_d        = 1'b0;
      error_d       = error_q;
      err_layer_d   = err_layer_q;
      pass_cycles_d = pass_cycles_q;
      frame_cnt_d   = frame_cnt_q;
    end

    l1_start_d = (state_d == ST_L1_GO);
    l2_start_d = (state_d == ST_L2_GO);
    l3_start_d = (state_d == ST_L3_GO);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      l1_start_q    <= 1'b0;
      l2_start_q    <= 1'b0;
      l3_start_q    <= 1'b0;
      out_latch_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_layer_q   <= LAYER_NONE;
      cyc_q         <= '0;
      pass_cycles_q <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      l1_start_q    <= l1_start_d;
      l2_start_q    <= l2_start_d;
      l3_start_q    <= l3_start_d;
      out_latch_q   <= out_latch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_layer_q   <= err_layer_d;
      cyc_q         <= cyc_d;
      pass_cycles_q <= pass_cycles_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign l1_start    = l1_start_q;
  assign l2_start    = l2_start_q;
  assign l3_start    = l3_start_q;
  assign out_latch   = out_latch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_layer   = err_layer_q;
  assign pass_cycles = pass_cycles_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_gen_layer_sequencer.sv
// Self-checking bench for gen_layer_sequencer; timeout scenario depends on GEN_SEQ_TIMEOUT_EN.
module tb_gen_layer_sequencer;

  logic        clk, rst, start, abort;
  logic        l1_done, l2_done, l3_done;
  logic        l1_start, l2_start, l3_start, out_latch, busy, done, error;
  logic [1:0]  err_layer;
  logic [15:0] pass_cycles, frame_cnt;
  // Narrow-counter instance sharing the same stimulus, for saturation/wrap.
  logic        s_l1_start, s_l2_start, s_l3_start, s_out_latch, s_busy, s_done, s_error;
  logic [1:0]  s_err_layer;
  logic [3:0]  s_pass_cycles, s_frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_frame;

  gen_layer_sequencer #(.TIMEOUT_CYCLES(50), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .l1_start(l1_start), .l2_start(l2_start), .l3_start(l3_start),
    .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
    .out_latch(out_latch), .busy(busy), .done(done), .error(error),
    .err_layer(err_layer), .pass_cycles(pass_cycles), .frame_cnt(frame_cnt)
  );

  gen_layer_sequencer #(.TIMEOUT_CYCLES(50), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .l1_start(s_l1_start), .l2_start(s_l2_start), .l3_start(s_l3_start),
    .l1_done(l1_done), .l2_done(l2_done), .l3_done(l3_done),
    .out_latch(s_out_latch), .busy(s_busy), .done(s_done), .error(s_error),
    .err_layer(s_err_layer), .pass_cycles(s_pass_cycles), .frame_cnt(s_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st, ab, d1, d2, d3;
    logic [5:0]  ctl;   // {l1_start,l2_start,l3_start,busy,done,out_latch}
    logic [15:0] frm, pas;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic st, logic ab, logic d1, logic d2, logic d3,
                              logic [5:0] ctl, logic [15:0] frm, logic [15:0] pas);
    vec_t v;
    v.st = st; v.ab = ab; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ctl = ctl; v.frm = frm; v.pas = pas;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs a pass that was already started; layer models answer d1/d2/d3 cycles after each start pulse.
  task automatic run_pass(input int d1, input int d2, input int d3,
                          output int busy_n, output int n1, output int n2, output int n3,
                          output int nd, output int nl, output bit ok, output bit tmo);
    int c1, c2, c3, i1, i2, i3, id, i3d, k;
    c1 = -1; c2 = -1; c3 = -1;
    i1 = -1; i2 = -1; i3 = -1; id = -1; i3d = -2;
    busy_n = 0; n1 = 0; n2 = 0; n3 = 0; nd = 0; nl = 0; ok = 1'b1; tmo = 1'b1;
    for (k = 0; k < 1000; k++) begin
      if (busy) busy_n++;
      if (l1_start) begin n1++; i1 = k; end
      if (l2_start) begin n2++; i2 = k; end
      if (l3_start) begin n3++; i3 = k; end
      if (done) begin nd++; id = k; end
      if (out_latch) nl++;
      if (done !== out_latch) ok = 1'b0;
      if (nd > 0 && !busy) begin tmo = 1'b0; break; end
      l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
      if (l1_start) c1 = d1; else if (c1 > 0) c1--;
      if (c1 == 0) begin l1_done = 1'b1; c1 = -1; end
      if (l2_start) c2 = d2; else if (c2 > 0) c2--;
      if (c2 == 0) begin l2_done = 1'b1; c2 = -1; end
      if (l3_start) c3 = d3; else if (c3 > 0) c3--;
      if (c3 == 0) begin l3_done = 1'b1; c3 = -1; i3d = k; end
      tick();
    end
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    if (!(i1 >= 0 && i1 < i2 && i2 < i3 && i3 < id && id == i3d + 1)) ok = 1'b0;
  endtask

  task automatic check_pass(input string name, input int busy_n, input int n1, input int n2,
                            input int n3, input int nd, input int nl, input bit ok, input bit tmo);
    chk({name, "_finished"}, {63'd0, tmo}, 64'd0);
    chk({name, "_pulse_counts"}, {n1[7:0], n2[7:0], n3[7:0], nd[7:0], nl[7:0]}, 40'h01_01_01_01_01);
    chk({name, "_order_latency"}, {63'd0, ok}, 64'd1);
    chk({name, "_frame_cnt"}, {48'd0, frame_cnt}, {48'd0, exp_frame});
    chk({name, "_pass_cycles"}, {48'd0, pass_cycles}, busy_n);
    chk({name, "_small_pass_sat"}, {60'd0, s_pass_cycles}, (busy_n > 15) ? 15 : busy_n);
  endtask

  initial begin
    int bn, n1, n2, n3, nd, nl, nw;
    bit ok, tmo;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    exp_frame = 16'd0;

    vecs[0]  = mk(1,0,0,0,0, 6'b100100, 0, 0);
    vecs[1]  = mk(0,0,1,1,1, 6'b000100, 0, 0);
    vecs[2]  = mk(0,0,0,1,1, 6'b000100, 0, 0);
    vecs[3]  = mk(0,0,0,0,0, 6'b000100, 0, 0);
    vecs[4]  = mk(0,0,1,0,0, 6'b010100, 0, 0);
    vecs[5]  = mk(0,0,0,0,0, 6'b000100, 0, 0);
    vecs[6]  = mk(0,0,0,1,0, 6'b001100, 0, 0);
    vecs[7]  = mk(0,0,0,0,0, 6'b000100, 0, 0);
    vecs[8]  = mk(0,0,0,0,1, 6'b000111, 1, 9);
    vecs[9]  = mk(0,0,0,0,0, 6'b000000, 1, 9);
    vecs[10] = mk(0,0,0,0,0, 6'b000000, 1, 9);
    vecs[11] = mk(1,0,0,0,0, 6'b100100, 1, 9);
    vecs[12] = mk(0,1,0,0,0, 6'b000000, 1, 9);
    vecs[13] = mk(1,0,0,0,0, 6'b100100, 1, 9);
    vecs[14] = mk(0,0,0,0,0, 6'b000100, 1, 9);
    vecs[15] = mk(0,0,1,0,0, 6'b010100, 1, 9);
    vecs[16] = mk(0,0,0,0,0, 6'b000100, 1, 9);
    vecs[17] = mk(0,1,0,1,0, 6'b000000, 1, 9);
    vecs[18] = mk(0,0,0,0,0, 6'b000000, 1, 9);

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset_outputs", {l1_start, l2_start, l3_start, out_latch, busy, done, error,
                          err_layer, pass_cycles, frame_cnt}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Table: short pass with stray done strobes, then aborts.
    for (int i = 0; i < 19; i++) begin
      start = vecs[i].st; abort = vecs[i].ab;
      l1_done = vecs[i].d1; l2_done = vecs[i].d2; l3_done = vecs[i].d3;
      tick();
      chk($sformatf("vec%0d", i),
          {l1_start, l2_start, l3_start, busy, done, out_latch, frame_cnt, pass_cycles},
          {vecs[i].ctl, vecs[i].frm, vecs[i].pas});
    end
    start = 1'b0; abort = 1'b0; l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    exp_frame = 16'd1;
    chk("table_no_error", {62'd0, error, s_error}, 64'd0);

    // Nominal pass with 10/20/30 cycle layers.
    start = 1'b1; tick(); start = 1'b0;
    run_pass(10, 20, 30, bn, n1, n2, n3, nd, nl, ok, tmo);
    exp_frame = 16'd2;
    check_pass("nominal", bn, n1, n2, n3, nd, nl, ok, tmo);

    // Reset while waiting on layer 3.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    tick();
    l2_done = 1'b1; tick(); l2_done = 1'b0;
    tick();
    chk("l3_wait_reached", {61'd0, l3_start, busy, done}, 64'b010);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_mid_pass", {l1_start, l2_start, l3_start, out_latch, busy, done, error,
                                 err_layer, pass_cycles, frame_cnt}, 64'd0);
    #1 rst = 1'b0;
    exp_frame = 16'd0;
    tick();
    chk("post_reset_idle", {47'd0, busy, frame_cnt}, 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    run_pass(3, 4, 5, bn, n1, n2, n3, nd, nl, ok, tmo);
    exp_frame = 16'd1;
    check_pass("after_reset", bn, n1, n2, n3, nd, nl, ok, tmo);

    // Back-to-back: start held high through the whole first pass.
    start = 1'b1; tick();
    run_pass(2, 2, 2, bn, n1, n2, n3, nd, nl, ok, tmo);
    exp_frame = 16'd2;
    check_pass("b2b_first", bn, n1, n2, n3, nd, nl, ok, tmo);
    tick();
    chk("b2b_second_start", {62'd0, l1_start, busy}, 64'b11);
    start = 1'b0;
    run_pass(2, 3, 4, bn, n1, n2, n3, nd, nl, ok, tmo);
    exp_frame = 16'd3;
    check_pass("b2b_second", bn, n1, n2, n3, nd, nl, ok, tmo);

    // Layer 2 never answers.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    l1_done = 1'b1; tick(); l1_done = 1'b0;
    chk("tmo_l2_go", {63'd0, l2_start}, 64'd1);
`ifdef GEN_SEQ_TIMEOUT_EN
    nw = 0;
    while (!error && nw < 200) begin
      tick();
      if (!error) nw++;
    end
    chk("tmo_wait_cycles", nw, 50);
    chk("tmo_err_state", {59'd0, busy, error, err_layer, done}, {59'd0, 1'b1, 1'b1, 2'd2, 1'b0});
    tick();
    chk("tmo_idle_sticky", {60'd0, busy, error, err_layer}, {60'd0, 1'b0, 1'b1, 2'd2});
    start = 1'b1; tick(); start = 1'b0;
    chk("tmo_cleared_by_start", {60'd0, l1_start, error, err_layer}, {60'd0, 1'b1, 1'b0, 2'd0});
`else
    nw = 0;
    repeat (200) begin
      tick();
      if (busy && !error) nw++;
    end
    chk("no_tmo_still_waiting", nw, 200);
    chk("no_tmo_flags", {60'd0, busy, error, err_layer}, {60'd0, 1'b1, 1'b0, 2'd0});
`endif
    abort = 1'b1; tick(); abort = 1'b0;
    chk("tmo_abort_idle", {47'd0, busy, frame_cnt}, {47'd0, 1'b0, exp_frame});
    chk("small_frame_cnt", {60'd0, s_frame_cnt}, {60'd0, exp_frame[3:0]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
